// File: rtl/fb_rect_fill_pkg.sv
// Shared framebuffer constants for the HDMI pipeline and the rectangle-fill FSM state type.
package hdmi_const;
   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 180;
   localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;
   localparam int FB_ADDR_W = 17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;
endpackage

// File: rtl/fb_rect_fill_if.sv
// Write-side bus into the double-buffered frame buffer; addresses are byte-style (pixel index << 1).
interface frame_buffer_bus
   import hdmi_const::*;
();
   logic [15:0]          write_data;
   logic [FB_ADDR_W-1:0] write_addr;
   logic                 write_enable;
   logic                 write_clk;
   logic                 swap_buffer;
   logic [15:0]          debug_read;

   modport WRITE (
      output write_data,
      output write_addr,
      output write_enable,
      output write_clk,
      output swap_buffer
   );

   modport FB (
      input  write_data,
      input  write_addr,
      input  write_enable,
      input  write_clk,
      input  swap_buffer,
      output debug_read
   );
endinterface

// File: rtl/fb_rect_fill_clip.sv
// Clips a rectangle command against the framebuffer and flags rectangles that draw nothing.
module fb_rect_clip
#(
   parameter int FB_W = 320,
   parameter int FB_H = 180
) (
   input  logic [8:0] x_i,
   input  logic [7:0] y_i,
   input  logic [8:0] w_i,
   input  logic [7:0] h_i,
   output logic [9:0] xe_o,
   output logic [9:0] ye_o,
   output logic       empty_o
);
   localparam logic [9:0] W10 = 10'(FB_W);
   localparam logic [9:0] H10 = 10'(FB_H);

   logic [9:0] x_end, y_end;

   always_comb begin
      x_end   = {1'b0, x_i} + {1'b0, w_i};
      y_end   = {2'b00, y_i} + {2'b00, h_i};
      xe_o    = (x_end > W10) ? W10 : x_end;
      ye_o    = (y_end > H10) ? H10 : y_end;
      empty_o = ({1'b0, x_i} >= W10) || ({2'b00, y_i} >= H10) ||
                (w_i == 9'd0) || (h_i == 8'd0);
   end
endmodule

// File: rtl/fb_rect_fill.sv
// Filled-rectangle drawing engine: one RGB565 pixel per cycle into the back buffer,
// with buffer swaps deferred until no rectangle is in flight.
module fb_rect_fill
   import hdmi_const::*;
#(
   parameter int FB_W = hdmi_const::FB_WIDTH,
   parameter int FB_H = hdmi_const::FB_HEIGHT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        cmd_valid_in,
   output logic        cmd_ready_out,
   input  logic [8:0]  cmd_x_in,
   input  logic [7:0]  cmd_y_in,
   input  logic [8:0]  cmd_w_in,
   input  logic [7:0]  cmd_h_in,
   input  logic [15:0] cmd_color_in,
   input  logic        swap_req_in,
   output logic        busy_out,
   output logic        done_out,
   frame_buffer_bus.WRITE bus
);
   localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(FB_W);

   fill_state_t          state_q;
   logic                 swap_pending_q, swap_q;
   logic [8:0]           x0_q, cx_q;
   logic [7:0]           cy_q;
   logic [9:0]           xe_q, ye_q;
   logic [FB_ADDR_W-1:0] row_base_q;
   logic                 we_q;
   logic [15:0]          wdata_q;
   logic [FB_ADDR_W-1:0] waddr_q;

   logic [9:0]           xe_c, ye_c;
   logic                 empty_c;
   logic                 accept, swap_want, last_col, last_row;
   logic [8:0]           cx_d;
   logic [7:0]           cy_d;
   logic [FB_ADDR_W-1:0] row_base_d, first_base;

   function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [FB_ADDR_W-1:0] base,
                                                     input logic [8:0] col);
      return (base + FB_ADDR_W'(col)) << 1;
   endfunction

   fb_rect_clip #(.FB_W(FB_W), .FB_H(FB_H)) u_clip (
      .x_i    (cmd_x_in),
      .y_i    (cmd_y_in),
      .w_i    (cmd_w_in),
      .h_i    (cmd_h_in),
      .xe_o   (xe_c),
      .ye_o   (ye_c),
      .empty_o(empty_c)
   );

   assign cmd_ready_out = (state_q == IDLE) && !swap_pending_q && !swap_q;
   assign busy_out      = (state_q != IDLE) || swap_pending_q;
   assign done_out      = (state_q == DONE);

   assign bus.write_clk    = clk_in;
   assign bus.write_enable = we_q;
   assign bus.write_data   = wdata_q;
   assign bus.write_addr   = waddr_q;
   assign bus.swap_buffer  = swap_q;

   always_comb begin
      swap_want  = swap_pending_q | swap_req_in;
      accept     = cmd_valid_in & cmd_ready_out;
      last_col   = (({1'b0, cx_q} + 10'd1) == xe_q);
      last_row   = (({2'b00, cy_q} + 10'd1) == ye_q);
      // Only the starting row needs y*FB_W; a constant multiply folds into shifts and adds.
      first_base = FB_ADDR_W'(cmd_y_in) * ROW_STEP;
      cx_d       = cx_q + 9'd1;
      cy_d       = cy_q;
      row_base_d = row_base_q;
      if (last_col) begin
         cx_d       = x0_q;
         cy_d       = cy_q + 8'd1;
         row_base_d = row_base_q + ROW_STEP;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q        <= IDLE;
         swap_pending_q <= 1'b0;
         swap_q         <= 1'b0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         waddr_q        <= '0;
         x0_q           <= '0;
         cx_q           <= '0;
         cy_q           <= '0;
         xe_q           <= '0;
         ye_q           <= '0;
         row_base_q     <= '0;
      end else begin
         swap_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x0_q           <= cmd_x_in;
                  cx_q           <= cmd_x_in;
                  cy_q           <= cmd_y_in;
                  xe_q           <= xe_c;
                  ye_q           <= ye_c;
                  row_base_q     <= first_base;
                  wdata_q        <= cmd_color_in;
                  swap_pending_q <= swap_want;
                  if (empty_c) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= FILL;
                     we_q    <= 1'b1;
                     waddr_q <= pix_addr(first_base, cmd_x_in);
                  end
               end else if (swap_want && !swap_q) begin
                  swap_q         <= 1'b1;
                  swap_pending_q <= 1'b0;
               end else begin
                  swap_pending_q <= swap_want;
               end
            end
            FILL: begin
               swap_pending_q <= swap_want;
               if (last_col && last_row) begin
                  we_q    <= 1'b0;
                  state_q <= DONE;
               end else begin
                  cx_q       <= cx_d;
                  cy_q       <= cy_d;
                  row_base_q <= row_base_d;
                  waddr_q    <= pix_addr(row_base_d, cx_d);
               end
            end
            DONE: begin
               state_q <= IDLE;
               // A deferred swap goes out right away, so ready stays low until it is served.
               if (swap_want) begin
                  swap_q         <= 1'b1;
                  swap_pending_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: directed and randomized rectangles checked against a raster model.
module tb_fb_rect_fill;
   import hdmi_const::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, swap_req, busy, done;
   logic [8:0]  cmd_x, cmd_w;
   logic [7:0]  cmd_y, cmd_h;
   logic [15:0] cmd_color;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int c;
      int addr;
      int data;
   } wr_t;

   wr_t wr_q[$];
   int  done_q[$];
   int  swp_q[$];
   bit  rdy_at[int];
   int  overlap_n = 0;

   frame_buffer_bus bus();
   assign bus.debug_read = '0;

   fb_rect_fill dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .cmd_valid_in (cmd_valid),
      .cmd_ready_out(cmd_ready),
      .cmd_x_in     (cmd_x),
      .cmd_y_in     (cmd_y),
      .cmd_w_in     (cmd_w),
      .cmd_h_in     (cmd_h),
      .cmd_color_in (cmd_color),
      .swap_req_in  (swap_req),
      .busy_out     (busy),
      .done_out     (done),
      .bus          (bus.WRITE)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.write_enable) wr_q.push_back('{cyc, int'(bus.write_addr), int'(bus.write_data)});
      if (done) done_q.push_back(cyc);
      if (bus.swap_buffer) swp_q.push_back(cyc);
      if (bus.write_enable && bus.swap_buffer) overlap_n++;
      rdy_at[cyc] = cmd_ready;
   end

   task automatic clear_logs();
      wr_q.delete();
      done_q.delete();
      swp_q.delete();
      rdy_at.delete();
      overlap_n = 0;
   endtask

   task automatic send_cmd(input int x, input int y, input int w, input int h,
                           input int color, input bit with_swap, output int acc);
      int budget = 0;
      acc = -1;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_x = x[8:0]; cmd_y = y[7:0]; cmd_w = w[8:0]; cmd_h = h[7:0];
      cmd_color = color[15:0];
      swap_req = with_swap;
      while (!cmd_ready && budget < 400) begin
         @(posedge clk); #1;
         budget++;
      end
      if (cmd_ready) acc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      swap_req  = 1'b0;
   endtask

   // Reference: expected pixel list from the clipped rectangle, then timing relative to acceptance.
   task automatic check_cmd(input string name, input int x, input int y, input int w,
                            input int h, input int color, input int acc, input bit swap_after);
      int exp_addr[$];
      int xe, ye, n, budget;
      checks++;
      if (acc < 0) begin
         errors++;
         $display("FAIL %s accept: ready never seen, required within 400 cycles", name);
         return;
      end
      xe = (x + w > FB_WIDTH) ? FB_WIDTH : x + w;
      ye = (y + h > FB_HEIGHT) ? FB_HEIGHT : y + h;
      if (!(x >= FB_WIDTH || y >= FB_HEIGHT || w == 0 || h == 0))
         for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
               exp_addr.push_back(2 * (r * FB_WIDTH + c));
      n = exp_addr.size();
      budget = 0;
      while (done_q.size() == 0 && budget < n + 100) begin
         @(negedge clk);
         budget++;
      end
      repeat (3) @(negedge clk);

      checks++;
      if (wr_q.size() != n) begin
         errors++;
         $display("FAIL %s write_count: got %0d, expected %0d", name, wr_q.size(), n);
      end
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== color || wr_q[i].c !== acc + 1 + i) begin
            errors++;
            $display("FAIL %s write[%0d]: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                     name, i, wr_q[i].addr, wr_q[i].data, wr_q[i].c - acc,
                     exp_addr[i], color, 1 + i);
         end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != acc + n + 1) begin
         errors++;
         $display("FAIL %s done: got %0d pulses first at rel %0d, expected 1 pulse at rel %0d",
                  name, done_q.size(), (done_q.size() > 0) ? done_q[0] - acc : -1, n + 1);
      end
      checks++;
      if (rdy_at[acc + n + 1] !== 1'b0 || rdy_at[acc + n + 2] !== !swap_after) begin
         errors++;
         $display("FAIL %s ready: got %0b,%0b at rel %0d,%0d, expected 0,%0b",
                  name, rdy_at[acc + n + 1], rdy_at[acc + n + 2], n + 1, n + 2, !swap_after);
      end
      checks++;
      if (swap_after) begin
         if (swp_q.size() != 1 || swp_q[0] != acc + n + 2 || rdy_at[acc + n + 3] !== 1'b1) begin
            errors++;
            $display("FAIL %s swap: got %0d pulses first at rel %0d, ready=%0b; expected 1 at rel %0d, ready=1",
                     name, swp_q.size(), (swp_q.size() > 0) ? swp_q[0] - acc : -1,
                     rdy_at[acc + n + 3], n + 2);
         end
      end else if (swp_q.size() != 0) begin
         errors++;
         $display("FAIL %s swap: got %0d pulses, expected 0", name, swp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b, expected 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b, expected 0", done); end
      checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL reset we: got %b, expected 0", bus.write_enable); end
      checks++; if (bus.write_data !== 16'h0) begin errors++; $display("FAIL reset wdata: got %h, expected 0", bus.write_data); end
      checks++; if (bus.write_addr !== 17'h0) begin errors++; $display("FAIL reset waddr: got %h, expected 0", bus.write_addr); end
      checks++; if (bus.swap_buffer !== 1'b0) begin errors++; $display("FAIL reset swap: got %b, expected 0", bus.swap_buffer); end
   endtask

   task automatic test_basic();
      int acc;
      clear_logs();
      send_cmd(10, 5, 3, 2, 16'hF800, 1'b0, acc);
      check_cmd("basic", 10, 5, 3, 2, 16'hF800, acc, 1'b0);
      checks++;
      if (wr_q.size() != 6 || wr_q[0].addr != 3220 || wr_q[5].addr != 3864) begin
         errors++;
         $display("FAIL basic corners: got %0d writes, expected 6 from 3220 to 3864", wr_q.size());
      end
   endtask

   task automatic test_clip();
      int acc;
      clear_logs();
      send_cmd(318, 179, 5, 5, 16'h07E0, 1'b0, acc);
      check_cmd("clip", 318, 179, 5, 5, 16'h07E0, acc, 1'b0);
      checks++;
      if (wr_q.size() != 2 || wr_q[0].addr != 115196 || wr_q[1].addr != 115198) begin
         errors++;
         $display("FAIL clip addrs: got %0d writes, expected 115196,115198", wr_q.size());
      end
   endtask

   task automatic test_empty();
      int acc;
      clear_logs();
      send_cmd(40, 20, 0, 7, 16'h001F, 1'b0, acc);
      check_cmd("empty_w0", 40, 20, 0, 7, 16'h001F, acc, 1'b0);
      clear_logs();
      send_cmd(320, 20, 9, 7, 16'h001F, 1'b0, acc);
      check_cmd("empty_x320", 320, 20, 9, 7, 16'h001F, acc, 1'b0);
   endtask

   task automatic test_random();
      int acc, x, y, w, h, col;
      for (int i = 0; i < 24; i++) begin
         x   = $urandom_range(0, 330);
         y   = $urandom_range(0, 190);
         w   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 24);
         h   = $urandom_range(0, 10);
         col = $urandom_range(0, 65535);
         clear_logs();
         send_cmd(x, y, w, h, col, 1'b0, acc);
         check_cmd("random", x, y, w, h, col, acc, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      int acc1, acc2;
      clear_logs();
      send_cmd(100, 50, 3, 2, 16'h1234, 1'b0, acc1);
      send_cmd(200, 60, 2, 2, 16'h1234, 1'b0, acc2);
      repeat (8) @(negedge clk);
      checks++;
      if (acc1 < 0 || acc2 != acc1 + 8) begin
         errors++;
         $display("FAIL b2b accept: got rel %0d, expected 8", acc2 - acc1);
      end
      checks++;
      if (wr_q.size() != 10 || wr_q[6].c != acc2 + 1 || wr_q[6].addr != 2 * (60 * 320 + 200)) begin
         errors++;
         $display("FAIL b2b writes: got %0d writes, expected 10 with second burst at rel 1", wr_q.size());
      end
   endtask

   task automatic test_swap_idle();
      int t;
      clear_logs();
      @(posedge clk); #1;
      t = cyc;
      swap_req = 1'b1;
      @(posedge clk); #1;
      swap_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (swp_q.size() != 1 || swp_q[0] != t + 1 || rdy_at[t + 1] !== 1'b0 || rdy_at[t + 2] !== 1'b1) begin
         errors++;
         $display("FAIL swap_idle: got %0d pulses, ready %0b,%0b; expected 1 pulse at t+1, ready 0,1",
                  swp_q.size(), rdy_at[t + 1], rdy_at[t + 2]);
      end
   endtask

   task automatic test_swap_fill();
      int acc;
      clear_logs();
      send_cmd(20, 30, 4, 4, 16'hABCD, 1'b0, acc);
      @(posedge clk); #1 swap_req = 1'b1;
      @(posedge clk); #1 swap_req = 1'b0;
      repeat (4) @(posedge clk);
      #1 swap_req = 1'b1;
      @(posedge clk); #1 swap_req = 1'b0;
      check_cmd("swap_fill", 20, 30, 4, 4, 16'hABCD, acc, 1'b1);
      checks++;
      if (overlap_n != 0) begin
         errors++;
         $display("FAIL swap_fill overlap: got %0d cycles, expected 0", overlap_n);
      end
      clear_logs();
      send_cmd(5, 5, 2, 3, 16'h5555, 1'b1, acc);
      check_cmd("swap_with_cmd", 5, 5, 2, 3, 16'h5555, acc, 1'b1);
   endtask

   task automatic test_reset_mid_fill();
      int acc;
      clear_logs();
      send_cmd(60, 70, 4, 4, 16'h0F0F, 1'b0, acc);
      swap_req = 1'b1;
      @(posedge clk); #1 swap_req = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (wr_q.size() != 3 || (wr_q.size() > 0 && wr_q[wr_q.size() - 1].c != acc + 3)) begin
         errors++;
         $display("FAIL rst_fill writes: got %0d, expected 3 ending at rel 3", wr_q.size());
      end
      checks++;
      if (swp_q.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("FAIL rst_fill swap/done: got %0d/%0d, expected 0/0", swp_q.size(), done_q.size());
      end
      checks++;
      if (rdy_at[acc + 4] !== 1'b1) begin
         errors++;
         $display("FAIL rst_fill ready: got %0b, expected 1", rdy_at[acc + 4]);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; swap_req = 1'b0;
      cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
      test_reset();
      test_basic();
      test_clip();
      test_empty();
      test_random();
      test_back_to_back();
      test_swap_idle();
      test_swap_fill();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at 500000");
      $fatal(1);
   end
endmodule
